// File: rtl/router_lut_stream.sv
// Associative destination-to-port routing table with a setup path that programs entries
// and a valid/ready route path that returns a registered port/hit result one cycle after accept.
module router_lut_stream #(
  parameter int ADDR_W       = 8,
  parameter int PORT_W       = 2,
  parameter int DEPTH        = 8,
  parameter int DEFAULT_PORT = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         setup,
  input  logic                         clr,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [ADDR_W-1:0]            Address,
  input  logic [PORT_W-1:0]            p,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [PORT_W-1:0]            Port,
  output logic                         hit,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full
);

  localparam int                 CNT_W     = $clog2(DEPTH + 1);
  localparam int                 IDX_W     = $clog2(DEPTH);
  localparam logic [PORT_W-1:0]  DEF_PORT  = PORT_W'(DEFAULT_PORT);
  localparam logic [CNT_W-1:0]   DEPTH_CNT = CNT_W'(DEPTH);
  localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DEPTH - 1);

  logic [DEPTH-1:0]  valid_r;
  logic [ADDR_W-1:0] addr_r [DEPTH];
  logic [PORT_W-1:0] port_r [DEPTH];
  logic [CNT_W-1:0]  count_r;
  logic              full_r;
  logic [IDX_W-1:0]  rp_r;
  logic              out_valid_r;
  logic [PORT_W-1:0] out_port_r;
  logic              hit_r;

  logic [DEPTH-1:0]  match_s;
  logic              match_any_s;
  logic [IDX_W-1:0]  match_idx_s;
  logic [IDX_W-1:0]  free_idx_s;
  logic [PORT_W-1:0] lookup_port_s;
  logic              in_ready_s;
  logic              accept_s;
  logic              route_acc_s;
  logic              wr_en_s;
  logic [IDX_W-1:0]  wr_idx_s;
  logic              cnt_inc_s;
  logic              rp_adv_s;
  logic [IDX_W-1:0]  rp_next_s;

  // Handshake: clear blocks intake; otherwise accept whenever the result slot can move.
  always_comb begin
    in_ready_s  = ~clr & (~out_valid_r | out_ready);
    accept_s    = in_valid & in_ready_s;
    route_acc_s = accept_s & ~setup;
  end

  // Parallel address compare against every valid entry.
  always_comb begin
    match_s = '0;
    for (int i = 0; i < DEPTH; i++) begin
      match_s[i] = valid_r[i] & (addr_r[i] == Address);
    end
    match_any_s = |match_s;
  end

  // Lowest-index encoders for the matching entry and the first free slot.
  always_comb begin
    match_idx_s = '0;
    free_idx_s  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      match_idx_s = match_s[i]  ? IDX_W'(i) : match_idx_s;
      free_idx_s  = ~valid_r[i] ? IDX_W'(i) : free_idx_s;
    end
    lookup_port_s = match_any_s ? port_r[match_idx_s] : DEF_PORT;
  end

  // Setup write target: update in place, else fill a free slot, else evict round-robin.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_idx_s  = '0;
    cnt_inc_s = 1'b0;
    rp_adv_s  = 1'b0;
    rp_next_s = (rp_r == LAST_IDX) ? '0 : rp_r + IDX_W'(1);
    if (accept_s && setup) begin
      wr_en_s = 1'b1;
      if (match_any_s) begin
        wr_idx_s = match_idx_s;
      end else if (!full_r) begin
        wr_idx_s  = free_idx_s;
        cnt_inc_s = 1'b1;
      end else begin
        wr_idx_s = rp_r;
        rp_adv_s = 1'b1;
      end
    end else begin
      wr_en_s = 1'b0;
    end
  end

  // Table storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_r <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= '0;
        port_r[i] <= '0;
      end
    end else if (clr) begin
      valid_r <= '0;
    end else if (wr_en_s) begin
      valid_r[wr_idx_s] <= 1'b1;
      addr_r[wr_idx_s]  <= Address;
      port_r[wr_idx_s]  <= p;
    end
  end

  // Occupancy and replacement pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r <= '0;
      full_r  <= 1'b0;
      rp_r    <= '0;
    end else if (clr) begin
      count_r <= '0;
      full_r  <= 1'b0;
      rp_r    <= '0;
    end else begin
      if (cnt_inc_s) begin
        count_r <= count_r + CNT_W'(1);
        full_r  <= ((count_r + CNT_W'(1)) == DEPTH_CNT);
      end
      if (rp_adv_s) begin
        rp_r <= rp_next_s;
      end
    end
  end

  // Result register; clear does not disturb a pending result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid_r <= 1'b0;
      out_port_r  <= DEF_PORT;
      hit_r       <= 1'b0;
    end else if (route_acc_s) begin
      out_valid_r <= 1'b1;
      out_port_r  <= lookup_port_s;
      hit_r       <= match_any_s;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_r;
  assign Port      = out_port_r;
  assign hit       = hit_r;
  assign count     = count_r;
  assign full      = full_r;

endmodule
